// File: rtl/usr_seq.sv
`default_nettype none
// ============================================================================
// Module   : usr_seq
// Purpose  : Sequenced universal shift register. Takes one command at a time
//            over a valid/ready handshake. Multi-step shift and rotate
//            operations then run on their own, one bit position per clock.
// Revision : 1.0 - initial release
// ============================================================================
module usr_seq #(
  parameter int N  = 8,
  parameter int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic [N-1:0]  p_data,
  input  logic          sin_left,
  input  logic          sin_right,
  input  logic          stall,
  input  logic          abort,
  output logic [N-1:0]  Q,
  output logic          sout_left,
  output logic          sout_right,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] c_OP_NOP   = 3'b000;
  localparam logic [2:0] c_OP_SHR   = 3'b001;
  localparam logic [2:0] c_OP_SHL   = 3'b010;
  localparam logic [2:0] c_OP_LOAD  = 3'b011;
  localparam logic [2:0] c_OP_ROR   = 3'b100;
  localparam logic [2:0] c_OP_ROL   = 3'b101;
  localparam logic [2:0] c_OP_ASR   = 3'b110;
  localparam logic [2:0] c_OP_CLEAR = 3'b111;

  localparam logic [AW-1:0] c_AMT_MAX = AW'(N);
  localparam logic [AW-1:0] c_AMT_ONE = AW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_q;
  logic [N-1:0]  w_q_nxt;
  logic [AW-1:0] r_rem;
  logic [AW-1:0] w_rem_nxt;
  logic [2:0]    r_op;
  logic [2:0]    w_op_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic [AW-1:0] w_amt_sat;
  logic [N-1:0]  w_step;

  // Requested counts beyond the register width behave as a full-width shift.
  assign w_amt_sat = (cmd_amt > c_AMT_MAX) ? c_AMT_MAX : cmd_amt;

  // One shift/rotate step of the latched operation applied to the current contents.
  always_comb begin
    w_step = r_q;
    case (r_op)
      c_OP_SHR: w_step = {sin_left, r_q[N-1:1]};
      c_OP_SHL: w_step = {r_q[N-2:0], sin_right};
      c_OP_ROR: w_step = {r_q[0], r_q[N-1:1]};
      c_OP_ROL: w_step = {r_q[N-2:0], r_q[N-1]};
      c_OP_ASR: w_step = {r_q[N-1], r_q[N-1:1]};
      default:  w_step = r_q;
    endcase
  end

  // Next-state logic: accept in IDLE, step/stall/abort in SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_op_nxt    = r_op;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            c_OP_NOP: begin
              w_done_nxt = 1'b1;
            end
            c_OP_LOAD: begin
              w_q_nxt    = p_data;
              w_done_nxt = 1'b1;
            end
            c_OP_CLEAR: begin
              w_q_nxt    = '0;
              w_done_nxt = 1'b1;
            end
            default: begin
              // A zero-count shift completes immediately and leaves Q untouched.
              if (w_amt_sat == '0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_op_nxt    = cmd_op;
                w_rem_nxt   = w_amt_sat;
                w_state_nxt = S_SHIFT;
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_rem_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (!stall) begin
          w_q_nxt   = w_step;
          w_rem_nxt = r_rem - c_AMT_ONE;
          if (r_rem == c_AMT_ONE) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_op    <= c_OP_NOP;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_op    <= w_op_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Q          = r_q;
  assign sout_left  = r_q[N-1];
  assign sout_right = r_q[0];
  assign busy       = (r_state == S_SHIFT);
  assign cmd_ready  = (r_state == S_IDLE);
  assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/usr_seq.md
# usr_seq

Parametrised sequenced universal shift register: the next generation of the team's universal shift register. Accepts one command at a time over a valid/ready handshake and executes multi-step shift/rotate operations autonomously, one bit position per clock. Supports hold, load, clear, logical, arithmetic and rotate shifts. Reports progress with busy/done and exposes both serial outputs for chaining. Sits in datapaths needing scheduled serialisation/deserialisation or bit-alignment under control of an upstream sequencer.

## Interface
- N, 8, register width (N >= 2)
- AW, $clog2(N+1), width of cmd_amt (derived; holds 0..N)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command; = !busy
- cmd_op  input  3  operation code, sampled on accept
- cmd_amt  input  AW  shift count, sampled on accept; values > N saturate to N
- p_data  input  N  parallel load data, sampled on accept
- sin_left  input  1  serial in at MSB for SHR, sampled at every shift edge
- sin_right  input  1  serial in at LSB for SHL, sampled at every shift edge
- stall  input  1  freezes an in-progress operation
- abort  input  1  terminates an in-progress operation
- Q  output  N  register contents
- sout_left  output  1  = Q[N-1]
- sout_right  output  1  = Q[0]
- busy  output  1  multi-step operation in progress
- done  output  1  one-cycle completion pulse

## Operation
- Op codes:
  - 000 NOP
  - 001 SHR: Q <= {sin_left, Q[N-1:1]}
  - 010 SHL: Q <= {Q[N-2:0], sin_right}
  - 011 LOAD: Q <= p_data
  - 100 ROR: Q <= {Q[0], Q[N-1:1]}
  - 101 ROL: Q <= {Q[N-2:0], Q[N-1]}
  - 110 ASR: Q <= {Q[N-1], Q[N-1:1]}
  - 111 CLEAR: Q <= 0
- Accept = cmd_valid && cmd_ready at a rising edge. cmd_valid while busy is ignored; no queueing.
- FSM states:
  - IDLE (busy=0, cmd_ready=1)
  - SHIFT (busy=1, cmd_ready=0)
- Single-step ops (NOP, LOAD, CLEAR), and shift ops with saturated amt = 0:
  - Effect applied at the accept edge.
  - done=1 for the following cycle.
  - FSM stays IDLE.
- Shift ops (001, 010, 100, 101, 110) with amt >= 1:
  - At accept: latch op; rem <= min(amt, N); go SHIFT. Q is unchanged at the accept edge.
  - In SHIFT, each edge with stall=0 and abort=0: apply one shift step; rem <= rem-1.
  - When that edge has rem==1: go IDLE; done <= 1.
- stall=1 in SHIFT: Q and rem hold. stall is ignored in IDLE.
- abort=1 in SHIFT: no shift; go IDLE; done stays 0. abort has priority over stall. abort is ignored in IDLE.
- Reset (rst=0) at any time:
  - Q=0, FSM=IDLE, rem=0, done=0.
  - Any operation in progress is discarded without done.
  - Reset values: busy=0, cmd_ready=1, sout_left=0, sout_right=0.

## Timing
- Single-step op: Q valid and done=1 one cycle after accept edge.
- Shift op with count k (1..N): shifts on the k edges after accept (plus one extra edge per stalled cycle). Q final and done=1 in the cycle after the last shift. Total latency k+1 cycles with no stall.
- done is registered, high exactly one cycle. A new command may be accepted in that same cycle (cmd_ready=1 concurrently).
- sout_left/sout_right are combinational from Q: the serial bit leaving on a shift edge is visible before that edge.
- busy and cmd_ready are registered-state decodes: busy rises the cycle after accept and falls in the done cycle.

## Test plan
- Reset: drive rst=0 mid-SHIFT (LOAD 0xA5, then SHR amt 5, reset after 2 shifts) -> Q=0x00, busy=0, cmd_ready=1, no done pulse.
- LOAD then ROL amt 3: LOAD 0x81, then ROL amt 3 -> busy for exactly 3 cycles, Q=0x0C, done 1 cycle; then ROR amt 8 -> Q back to 0x0C (full rotate).
- SHR with serial input: LOAD 0x00, SHR amt 4 with sin_left=1 throughout -> Q=0xF0. ASR from 0x80 amt 3 -> Q=0xF0. SHL amt 2 from 0x01 with sin_right=0 -> Q=0x04.
- Saturation/zero: SHL amt 15 (AW=4) with sin_right=0 on 0xFF -> exactly 8 shifts, Q=0x00. SHR amt 0 -> Q unchanged, done next cycle, busy never 1.
- Stall/abort: ROR amt 4 on 0x01 with stall=1 for 2 middle cycles -> 6 busy cycles, Q=0x10. Repeat with abort after 2 shifts -> Q=0x40, no done, cmd_ready=1 next cycle.
- Back-to-back: hold cmd_valid=1 with CLEAR queued behind a SHR amt 2 -> CLEAR accepted in the SHR done cycle, Q=0x00 the next cycle, second done pulse.
